run_length_collector: RTL and testbench
=======================================

RUN_LENGTH_COLLECTOR -- requirements
Module: run_length_collector

Interface
REQ-001 Parameter DEPTH, default 4, number of run-length FIFO entries (power of two, >=2).
REQ-002 Parameter LEN_W, default 8, width of a run length in bits.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 clear  input  1  synchronous flush of FSM, counter, FIFO and ovf.
REQ-006 in_en  input  1  qualifies in_; in_ sampled only when 1.
REQ-007 in_  input  1  match bit from the upstream registered XNOR/AND gate stage.
REQ-008 out_val  output  1  FIFO holds at least one run length.
REQ-009 out_rdy  input  1  consumer accepts out_len when out_val & out_rdy.
REQ-010 out_len  output  LEN_W  run length at FIFO head; 0 when out_val=0.
REQ-011 ovf  output  1  sticky flag: a completed run was dropped because the FIFO was full.

Function
REQ-012 FSM states IDLE and RUN; state, counter, FIFO and ovf are registers, outputs derive from registers only.
REQ-013 IDLE, sampled in_=1 -> RUN, cnt=1; sampled in_=0 -> stay IDLE.
REQ-014 RUN, sampled in_=1 -> stay RUN, cnt=cnt+1 saturating at 2^LEN_W-1 (no wrap).
REQ-015 RUN, sampled in_=0 -> push cnt into FIFO, go IDLE, cnt=0.
REQ-016 in_en=0 -> FSM and cnt hold; a run spans gaps in in_en.
REQ-017 Pushed length appears at out_len with out_val=1 on the cycle after the terminating sample edge (1-cycle latency when the FIFO was empty).
REQ-018 Pop occurs on a posedge where out_val & out_rdy; FIFO order strictly first-in first-out.
REQ-019 Push and pop on the same edge both succeed, including when FIFO is full; occupancy unchanged.
REQ-020 Push while full without a same-edge pop -> length discarded, FIFO unchanged, ovf set to 1 next cycle.
REQ-021 ovf remains 1 until clear or reset; it does not affect further pushes or pops.
REQ-022 FIFO read/write pointers wrap modulo DEPTH; occupancy counter ranges 0..DEPTH.
REQ-023 out_val, out_len must not depend combinationally on out_rdy, in_ or in_en.
REQ-024 clear=1 has priority over all other events on that edge: state IDLE, cnt=0, FIFO empty, ovf=0; in_ on that edge is ignored.

Reset
REQ-025 reset_n=0 immediately forces state IDLE, cnt=0, FIFO empty, out_val=0, out_len=0, ovf=0, independent of clk.
REQ-026 Reset asserted mid-run discards the partial run; no push occurs on reset release.
REQ-027 First sampling edge is the first posedge with reset_n=1.

Structure
REQ-028 Shared package run_length_pkg holds the FSM state enum (IDLE, RUN) and default DEPTH/LEN_W constants.
REQ-029 FIFO storage is one sub-module, run_length_fifo (parameterised DEPTH, LEN_W, push/pop/full/empty, async active-low reset).
REQ-030 FSM, counter and overflow logic reside in run_length_collector.

Verification
REQ-031 in_en=1, in_=0,1,1,1,0 -> out_val=1 with out_len=3 one cycle after the final 0 edge; out_rdy=1 pops it, out_val=0 next cycle.
REQ-032 LEN_W=8, run of 300 ones then 0 -> out_len=255.
REQ-033 out_rdy=0, five runs of lengths 1,2,3,4,5 (DEPTH=4) -> FIFO holds 1,2,3,4, ovf=1; draining yields 1,2,3,4 in order.
REQ-034 FIFO full, run ends on same edge as pop -> both succeed, occupancy stays 4, ovf stays 0.
REQ-035 Run of 2, in_en=0 for 3 cycles, then 1,0 -> single out_len=3.
REQ-036 reset_n pulsed low mid-run of 5, and separately clear mid-run with 2 entries queued -> out_val=0, ovf=0, next run of 1 reports out_len=1.

Source files
------------

// File: rtl/run_length_pkg.sv
// Shared types and default sizing for the run-length collector and its FIFO.
package run_length_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/run_length_fifo.sv
// Small synchronous FIFO holding completed run lengths; a push while full is
// accepted only when a pop frees the head slot on the same edge.
module run_length_fifo
    import run_length_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [LEN_W-1:0] push_data,
    input  logic             pop,
    output logic [LEN_W-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [LEN_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (PTR_W+1)'(DEPTH));
    assign empty     = (count_r == {(PTR_W+1){1'b0}});
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Head data is forced to zero while empty so stale entries never leak out.
    always_comb begin
        pop_data = {LEN_W{1'b0}};
        if (!empty) begin
            pop_data = mem_r[rd_ptr_r];
        end else begin
            pop_data = {LEN_W{1'b0}};
        end
    end

    // Storage write; data needs no reset because reads are masked by empty.
    always_ff @(posedge clk) begin
        if (do_push_s && !clear) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/run_length_collector.sv
// Measures runs of consecutive qualified 1 samples and queues each finished
// run length for a ready/valid consumer, flagging runs lost to a full queue.
module run_length_collector
    import run_length_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             in_en,
    input  logic             in_,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [LEN_W-1:0] out_len,
    output logic             ovf
);

    localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

    state_t           state_r;
    state_t           state_s;
    logic [LEN_W-1:0] cnt_r;
    logic [LEN_W-1:0] cnt_s;
    logic             ovf_r;
    logic             ovf_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    assign out_val = ~fifo_empty_s;
    assign pop_s   = out_val & out_rdy;
    assign ovf     = ovf_r;

    // Next-state, counter and overflow decisions for one sampling edge.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        push_s  = 1'b0;
        ovf_s   = ovf_r;
        if (in_en) begin
            case (state_r)
                IDLE: begin
                    if (in_) begin
                        state_s = RUN;
                        cnt_s   = LEN_W'(1);
                    end else begin
                        state_s = IDLE;
                        cnt_s   = {LEN_W{1'b0}};
                    end
                end
                RUN: begin
                    if (in_) begin
                        state_s = RUN;
                        cnt_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + LEN_W'(1);
                    end else begin
                        push_s  = 1'b1;
                        state_s = IDLE;
                        cnt_s   = {LEN_W{1'b0}};
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {LEN_W{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
            cnt_s   = cnt_r;
        end
        // A full queue only drops the run if the consumer is not freeing a slot.
        if (push_s && fifo_full_s && !pop_s) begin
            ovf_s = 1'b1;
        end else begin
            ovf_s = ovf_r;
        end
    end

    // FSM, run counter and sticky overflow registers; clear outranks sampling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= {LEN_W{1'b0}};
            ovf_r   <= 1'b0;
        end else if (clear) begin
            state_r <= IDLE;
            cnt_r   <= {LEN_W{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ovf_r   <= ovf_s;
        end
    end

    run_length_fifo #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .clear     (clear),
        .push      (push_s),
        .push_data (cnt_r),
        .pop       (pop_s),
        .pop_data  (out_len),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_run_length_collector.sv
// Directed bench for run_length_collector with a queue-based scoreboard of
// expected run lengths and a sticky-overflow expectation.
module tb_run_length_collector;

    localparam int DEPTH = 4;
    localparam int LEN_W = 8;
    localparam int LMAX  = 255;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             clear   = 1'b0;
    logic             in_en   = 1'b0;
    logic             in_     = 1'b0;
    logic             out_rdy = 1'b0;
    logic             out_val;
    logic [LEN_W-1:0] out_len;
    logic             ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int expq[$];
    int mrun      = 0;
    bit exp_ovf   = 1'b0;

    run_length_collector #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .in_en   (in_en),
        .in_     (in_),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_len (out_len),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Called at a negedge: checks the current outputs against the scoreboard,
    // drives one sample, updates the reference model and advances one cycle.
    task automatic cyc(input bit en, input bit b, input bit rdy);
        int head;
        in_en   = en;
        in_     = b;
        out_rdy = rdy;
        head    = (expq.size() != 0) ? expq[0] : 0;
        check("out_val", 32'(out_val), 32'(expq.size() != 0));
        check("out_len", 32'(out_len), 32'(head));
        check("ovf", 32'(ovf), 32'(exp_ovf));
        if (rdy && expq.size() != 0) void'(expq.pop_front());
        if (en) begin
            if (b) begin
                if (mrun < LMAX) mrun++;
            end else if (mrun != 0) begin
                if (expq.size() < DEPTH) expq.push_back(mrun);
                else exp_ovf = 1'b1;
                mrun = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit rdy);
        repeat (n) cyc(1'b1, 1'b1, rdy);
        cyc(1'b1, 1'b0, rdy);
    endtask

    task automatic drain();
        repeat (DEPTH + 1) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_clear();
        in_en   = 1'b1;
        in_     = 1'b1;
        out_rdy = 1'b1;
        clear   = 1'b1;
        expq.delete();
        mrun    = 0;
        exp_ovf = 1'b0;
        @(negedge clk);
        clear   = 1'b0;
        in_en   = 1'b0;
        in_     = 1'b0;
        out_rdy = 1'b0;
    endtask

    initial begin
        // Reset state, observed while reset is held.
        #1;
        check("rst_out_val", 32'(out_val), 32'd0);
        check("rst_out_len", 32'(out_len), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic run of three, then a pop.
        cyc(1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("len3_val", 32'(out_val), 32'd1);
        check("len3_len", 32'(out_len), 32'd3);
        cyc(1'b0, 1'b0, 1'b1);
        check("len3_popped", 32'(out_val), 32'd0);

        // Counter saturation.
        run(300, 1'b0);
        check("sat_len", 32'(out_len), 32'd255);
        drain();

        // Overflow: five runs into a four-deep queue.
        for (int k = 1; k <= 5; k++) run(k, 1'b0);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_head", 32'(out_len), 32'd1);
        drain();
        check("ovf_sticky", 32'(ovf), 32'd1);
        do_clear();

        // Full queue: run terminates on the same edge as a pop.
        for (int k = 1; k <= 4; k++) run(k, 1'b0);
        repeat (5) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        check("same_edge_ovf", 32'(ovf), 32'd0);
        check("same_edge_head", 32'(out_len), 32'd2);
        drain();

        // Run spanning an in_en gap.
        repeat (2) cyc(1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("gap_len", 32'(out_len), 32'd3);
        drain();

        // Asynchronous reset mid-run with a full queue and ovf set.
        for (int k = 1; k <= 5; k++) run(k, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_val", 32'(out_val), 32'd0);
        check("arst_out_len", 32'(out_len), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        expq.delete();
        mrun    = 0;
        exp_ovf = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        run(1, 1'b0);
        check("post_rst_len", 32'(out_len), 32'd1);
        drain();

        // Synchronous clear mid-run with two entries queued.
        run(1, 1'b0);
        run(2, 1'b0);
        repeat (2) cyc(1'b1, 1'b1, 1'b0);
        do_clear();
        check("clr_out_val", 32'(out_val), 32'd0);
        check("clr_ovf", 32'(ovf), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        run(1, 1'b0);
        check("post_clr_len", 32'(out_len), 32'd1);
        drain();
        check("final_empty", 32'(out_val), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
